sha_msg_schedule: RTL and testbench
===================================

// Module: sha_msg_schedule
// PURPOSE
//   Parametrised SHA-2 message-schedule expander; successor to the fixed 32-bit sigma-1 unit.
//   Accepts one 16-word message block, then streams schedule words W[0..ROUNDS-1], one per cycle.
//   Embeds both small-sigma functions (sigma0, sigma1) selected by WIDTH. Supports SHA-256 and SHA-512.
//   Sits between the block/padding front end and the compression round core; valid/ready on both sides.
// PARAMETERS
//   WIDTH   32  word width; 32 = SHA-256 constants, 64 = SHA-512 constants; other values illegal
//   ROUNDS  64  words emitted per block, legal 16..80 (use 80 with WIDTH=64)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous, active-low reset
//   abort     in   1      synchronous flush: drop current block, return to LOAD
//   in_valid  in   1      in_word valid
//   in_ready  out  1      block accepts a load word
//   in_word   in   WIDTH  message word, W[0] first
//   w_valid   out  1      w_out holds a valid schedule word
//   w_ready   in   1      consumer accepts w_out
//   w_out     out  WIDTH  schedule word W[w_idx]
//   w_idx     out  7      index t of w_out, 0..ROUNDS-1
//   w_last    out  1      w_valid && w_idx==ROUNDS-1
// BEHAVIOUR
//   Reset: state=LOAD, load_cnt=0, w_idx=0, window[0..15]=0, w_valid=0, w_last=0, in_ready=1, w_out=0.
//   Storage: 16-entry window win[0..15]; w_out is win[0] (registered, no comb path from inputs).
//   LOAD: in_ready=1, w_valid=0. Each in_valid&&in_ready: win[load_cnt]<=in_word, load_cnt++.
//     Handshake with load_cnt==15 -> EMIT, w_idx<=0; w_valid=1 next cycle with w_out=W[0].
//   EMIT: in_ready=0 (input ignored), w_valid=1. On w_valid&&w_ready:
//     win[i]<=win[i+1] for i=0..14; win[15]<=new = s1(win[14])+win[9]+s0(win[1])+win[0] mod 2^WIDTH;
//     w_idx++; if w_idx==ROUNDS-1 -> LOAD, load_cnt<=0, w_idx<=0, w_valid=0 next cycle.
//   Throughput 1 word/clk while w_ready=1; w_ready low: w_out, w_idx, window all hold (no loss).
//   Words W[16+] emitted are the computed expansion; W[0..15] are the loaded words unchanged.
//   WIDTH=32: s0=ROTR7^ROTR18^SHR3;  s1=ROTR17^ROTR19^SHR10.
//   WIDTH=64: s0=ROTR1^ROTR8^SHR7;   s1=ROTR19^ROTR61^SHR6.
//   Addition: 4-operand sum, carries beyond WIDTH discarded (wrap-around).
//   abort: highest priority over any handshake that cycle -> LOAD, load_cnt=0, w_idx=0, w_valid=0;
//     window contents not cleared (don't care). abort in LOAD mid-fill restarts fill at W[0].
//   Last-word handshake and next block: in_ready rises the cycle after w_last handshake (no overlap).
//   rst_n low at any time, incl. mid-EMIT: immediate return to reset values, no partial output.
// TESTING
//   1 SHA-256 "abc": load 0x61626380, 14x0, 0x00000018 -> W0=0x61626380, W15=0x00000018,
//     W16=0x61626380, W17=0x000F0000; w_last only on idx 63; exactly 64 words then in_ready=1.
//   2 All-zero block, WIDTH=32 -> 64 words all 0x00000000, w_idx 0..63 contiguous, w_ready held 1.
//   3 Backpressure: drop w_ready for 5 clks at idx 20 -> w_out/w_idx stable, sequence identical to case 1.
//   4 abort at idx 30, then reload "abc" -> output restarts at W0=0x61626380, idx 0; no stale words.
//   5 rst_n low mid-EMIT (idx 40) -> w_valid=0, in_ready=1 same cycle; subsequent block correct.
//   6 WIDTH=64, ROUNDS=80, W0=1, rest 0 -> W16=0x0000000000000001, w_last at idx 79; in_valid gaps
//     during LOAD (in_valid low 3 clks) do not shift word order.

Source files
------------

// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander: loads a 16-word block, then streams W[0..ROUNDS-1].
// WIDTH selects the SHA-256 (32) or SHA-512 (64) small-sigma functions.
module sha_msg_schedule #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_out,
  output logic [6:0]       w_idx,
  output logic             w_last
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  localparam int S0A = (WIDTH == 64) ? 1  : 7;
  localparam int S0B = (WIDTH == 64) ? 8  : 18;
  localparam int S0C = (WIDTH == 64) ? 7  : 3;
  localparam int S1A = (WIDTH == 64) ? 19 : 17;
  localparam int S1B = (WIDTH == 64) ? 61 : 19;
  localparam int S1C = (WIDTH == 64) ? 6  : 10;

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] x,
    input int               n
  );
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] sig0(
    input logic [WIDTH-1:0] x
  );
    return rotr(x, S0A) ^ rotr(x, S0B) ^ (x >> S0C);
  endfunction

  function automatic logic [WIDTH-1:0] sig1(
    input logic [WIDTH-1:0] x
  );
    return rotr(x, S1A) ^ rotr(x, S1B) ^ (x >> S1C);
  endfunction

  logic [0:0]       state;
  logic [3:0]       load_cnt;
  logic [WIDTH-1:0] win [16];
  logic [WIDTH-1:0] nxt;
  logic             load_hs;
  logic             emit_hs;

  assign in_ready = (state == LOAD);
  assign w_valid  = (state == EMIT);
  assign load_hs  = in_valid && in_ready;
  assign emit_hs  = w_valid && w_ready;
  assign w_out    = win[0];
  assign w_last   = w_valid && (w_idx == LAST);

  // win[0] is W[t], so the new tail entry is W[t+16]
  assign nxt = sig1(win[14]) + win[9]
             + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      w_idx    <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (abort) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      w_idx    <= 7'd0;
    end else begin
      unique case (1'b1)
        load_hs: begin
          win[load_cnt] <= in_word;
          load_cnt      <= load_cnt + 4'd1;
          if (load_cnt == 4'd15) begin
            state <= EMIT;
            w_idx <= 7'd0;
          end
        end
        emit_hs: begin
          for (int i = 0; i < 15; i++) begin
            win[i] <= win[i+1];
          end
          win[15] <= nxt;
          w_idx   <= w_idx + 7'd1;
          if (w_idx == LAST) begin
            state    <= LOAD;
            load_cnt <= 4'd0;
            w_idx    <= 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: SHA-256 and SHA-512 instances checked
// against a bit-level reference of the standard schedule recurrence.
module tb_sha_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        w_ready;
  logic        sel;
  logic [63:0] in_word;

  logic        in_ready_a, w_valid_a, w_last_a;
  logic [31:0] w_out_a;
  logic [6:0]  w_idx_a;
  logic        in_ready_b, w_valid_b, w_last_b;
  logic [63:0] w_out_b;
  logic [6:0]  w_idx_b;

  logic        o_in_ready, o_valid, o_last;
  logic [63:0] o_out;
  logic [6:0]  o_idx;

  int checks = 0;
  int failures = 0;

  logic [63:0] blk   [16];
  logic [63:0] exp_w [80];
  int          cur_w;
  int          cur_r;

  always #5 clk = ~clk;

  sha_msg_schedule #(.WIDTH(32), .ROUNDS(64)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid & ~sel),
    .in_ready (in_ready_a),
    .in_word  (in_word[31:0]),
    .w_valid  (w_valid_a),
    .w_ready  (w_ready),
    .w_out    (w_out_a),
    .w_idx    (w_idx_a),
    .w_last   (w_last_a)
  );

  sha_msg_schedule #(.WIDTH(64), .ROUNDS(80)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid & sel),
    .in_ready (in_ready_b),
    .in_word  (in_word),
    .w_valid  (w_valid_b),
    .w_ready  (w_ready),
    .w_out    (w_out_b),
    .w_idx    (w_idx_b),
    .w_last   (w_last_b)
  );

  assign o_in_ready = sel ? in_ready_b : in_ready_a;
  assign o_valid    = sel ? w_valid_b  : w_valid_a;
  assign o_last     = sel ? w_last_b   : w_last_a;
  assign o_out      = sel ? w_out_b    : {32'd0, w_out_a};
  assign o_idx      = sel ? w_idx_b    : w_idx_a;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? '1 : 64'hFFFF_FFFF;
  endfunction

  // rotation built bit by bit from its definition
  function automatic logic [63:0] ref_rotr(input logic [63:0] x,
                                           input int n,
                                           input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[(i + n) % w];
    return r;
  endfunction

  function automatic logic [63:0] ref_s0(input logic [63:0] x,
                                         input int w);
    if (w == 64)
      return ref_rotr(x, 1, 64) ^ ref_rotr(x, 8, 64) ^ (x >> 7);
    return ref_rotr(x, 7, 32) ^ ref_rotr(x, 18, 32) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] ref_s1(input logic [63:0] x,
                                         input int w);
    if (w == 64)
      return ref_rotr(x, 19, 64) ^ ref_rotr(x, 61, 64) ^ (x >> 6);
    return ref_rotr(x, 17, 32) ^ ref_rotr(x, 19, 32) ^ (x >> 10);
  endfunction

  task automatic build_expected();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t] & mask(cur_w);
    for (int t = 16; t < 80; t++)
      exp_w[t] = (ref_s1(exp_w[t-2], cur_w) + exp_w[t-7]
                + ref_s0(exp_w[t-15], cur_w) + exp_w[t-16])
                & mask(cur_w);
  endtask

  task automatic set_abc();
    foreach (blk[i]) blk[i] = '0;
    blk[0]  = 64'h6162_6380;
    blk[15] = 64'h18;
  endtask

  task automatic set_rand();
    foreach (blk[i]) blk[i] = {$urandom, $urandom} & mask(cur_w);
  endtask

  // gap_mode: 0 none, 1 three idle clocks before word 5, 2 random gaps
  task automatic load_blk(input int n, input int gap_mode);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = 0;
      if (gap_mode == 1 && i == 5) gap = 3;
      if (gap_mode == 2) gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_word  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      @(negedge clk);
      chk("load_in_ready", 64'(o_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic emit(input int n, input int stall_idx,
                      input int stall_len, input bit rand_bp);
    int t;
    int st;
    int guard;
    t = 0; st = 0; guard = 0;
    while (t < n && guard < n + 400) begin
      guard++;
      if (rand_bp) w_ready = ($urandom_range(0, 3) != 0);
      else w_ready = !(t == stall_idx && st < stall_len);
      in_valid = 1'($urandom_range(0, 1));
      in_word  = {$urandom, $urandom};
      @(negedge clk);
      chk("w_valid", 64'(o_valid), 64'd1);
      chk("emit_in_ready", 64'(o_in_ready), 64'd0);
      chk("w_idx", 64'(o_idx), 64'(t));
      chk("w_out", o_out, exp_w[t]);
      chk("w_last", 64'(o_last), 64'(t == cur_r - 1));
      if (!w_ready) st++;
      else t++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    w_ready  = 1'b1;
    chk("emit_count", 64'(t), 64'(n));
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_w_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
    chk({tag, "_w_idx"}, 64'(o_idx), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_abort(input bit with_valid);
    abort    = 1'b1;
    in_valid = with_valid;
    in_word  = {$urandom, $urandom};
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic full_block(input int gap_mode, input bit rand_bp);
    build_expected();
    load_blk(16, gap_mode);
    emit(cur_r, -1, 0, rand_bp);
    chk_idle("done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0;
    w_ready = 1'b1; sel = 1'b0; in_word = '0;
    cur_w = 32; cur_r = 64;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    chk("rst_w_valid_a", 64'(w_valid_a), 64'd0);
    chk("rst_w_last_a", 64'(w_last_a), 64'd0);
    chk("rst_w_idx_a", 64'(w_idx_a), 64'd0);
    chk("rst_w_out_a", 64'(w_out_a), 64'd0);
    chk("rst_w_out_b", w_out_b, 64'd0);
    chk("rst_w_valid_b", 64'(w_valid_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHA-256 "abc" block
    set_abc();
    full_block(0, 1'b0);

    // all-zero block
    foreach (blk[i]) blk[i] = '0;
    full_block(0, 1'b0);

    // backpressure at idx 20 for 5 clocks
    set_abc();
    build_expected();
    load_blk(16, 0);
    emit(64, 20, 5, 1'b0);
    chk_idle("bp");

    // abort at idx 30, then reload
    load_blk(16, 0);
    emit(30, -1, 0, 1'b0);
    do_abort(1'b0);
    chk_idle("abort");
    full_block(0, 1'b0);

    // abort mid-fill restarts at W[0]
    set_rand();
    load_blk(5, 0);
    do_abort(1'b1);
    chk_idle("abort_fill");
    set_rand();
    full_block(0, 1'b0);

    // reset asserted mid-EMIT at idx 40
    set_abc();
    build_expected();
    load_blk(16, 0);
    emit(40, -1, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(o_in_ready), 64'd1);
    chk("mid_rst_w_idx", 64'(o_idx), 64'd0);
    chk("mid_rst_w_out", o_out, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_abc();
    full_block(0, 1'b0);

    // random blocks, random gaps and backpressure
    for (int k = 0; k < 4; k++) begin
      set_rand();
      full_block(2, 1'b1);
    end

    // SHA-512 instance
    sel = 1'b1; cur_w = 64; cur_r = 80;
    @(posedge clk); #1;
    foreach (blk[i]) blk[i] = '0;
    blk[0] = 64'd1;
    full_block(1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      set_rand();
      full_block(2, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
